// File: rtl/adc_frame_averager_if.sv
// Frame input and averaged-measurement output bundle of the ADC frame averager.
// The averager connects through the slave modport and the SPI side through the master modport.
interface adc_frame_averager_if;
    logic [23:0] frame_data;
    logic        frame_valid;
    logic [7:0]  avg_v_panel;
    logic [7:0]  avg_i_panel;
    logic [7:0]  avg_v_cap;
    logic [15:0] p_panel;
    logic        avg_valid;
    logic        data_ready;
    logic        stale;
    logic [7:0]  err_count;

    modport master (
        output frame_data, frame_valid,
        input  avg_v_panel, avg_i_panel, avg_v_cap, p_panel,
        input  avg_valid, data_ready, stale, err_count
    );

    modport slave (
        input  frame_data, frame_valid,
        output avg_v_panel, avg_i_panel, avg_v_cap, p_panel,
        output avg_valid, data_ready, stale, err_count
    );
endinterface

// File: rtl/adc_frame_averager.sv
// Block-averages accepted SPI measurement frames over 2^LOG2_N samples, rejects idle-line
// frames and flags a stale link when no frame has been accepted for TIMEOUT cycles.
module adc_frame_averager #(
    parameter int LOG2_N  = 3,
    parameter int TIMEOUT = 50000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adc_frame_averager_if.slave  bus
);
    localparam int            AW       = 8 + LOG2_N;
    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {WAIT_FIRST, RUN, STALE} state_t;

    state_t            state;
    logic              fv_q;
    logic [AW-1:0]     acc_v, acc_i, acc_c;
    logic [LOG2_N-1:0] cnt;
    logic [TW-1:0]     tmo;

    logic          evt, bad, accept, last;
    logic [AW-1:0] sum_v, sum_i, sum_c;
    logic [7:0]    nxt_v, nxt_i, nxt_c;

    function automatic logic [7:0] avg_of(input logic [AW-1:0] s);
        return s[AW-1:LOG2_N];
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        evt    = bus.frame_valid & ~fv_q;
        bad    = (bus.frame_data == 24'h000000) | (bus.frame_data == 24'hFFFFFF);
        accept = evt & ~bad;
        last   = accept & (cnt == {LOG2_N{1'b1}});
        sum_v  = acc_v + AW'(bus.frame_data[23:16]);
        sum_i  = acc_i + AW'(bus.frame_data[15:8]);
        sum_c  = acc_c + AW'(bus.frame_data[7:0]);
        nxt_v  = avg_of(sum_v);
        nxt_i  = avg_of(sum_i);
        nxt_c  = avg_of(sum_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= WAIT_FIRST;
            fv_q            <= 1'b0;
            acc_v           <= '0;
            acc_i           <= '0;
            acc_c           <= '0;
            cnt             <= '0;
            tmo             <= '0;
            bus.avg_v_panel <= '0;
            bus.avg_i_panel <= '0;
            bus.avg_v_cap   <= '0;
            bus.p_panel     <= '0;
            bus.avg_valid   <= 1'b0;
            bus.data_ready  <= 1'b0;
            bus.stale       <= 1'b0;
            bus.err_count   <= '0;
        end else begin
            fv_q          <= bus.frame_valid;
            bus.avg_valid <= 1'b0;
            if (evt && bad)
                bus.err_count <= sat_inc(bus.err_count);

            if (accept) begin
                // An accept always wins over a coinciding timeout expiry.
                tmo <= '0;
                if (last) begin
                    acc_v           <= '0;
                    acc_i           <= '0;
                    acc_c           <= '0;
                    cnt             <= '0;
                    bus.avg_v_panel <= nxt_v;
                    bus.avg_i_panel <= nxt_i;
                    bus.avg_v_cap   <= nxt_c;
                    bus.p_panel     <= {8'h00, nxt_v} * {8'h00, nxt_i};
                    bus.avg_valid   <= 1'b1;
                    bus.data_ready  <= 1'b1;
                    state           <= RUN;
                end else begin
                    acc_v <= sum_v;
                    acc_i <= sum_i;
                    acc_c <= sum_c;
                    cnt   <= cnt + LOG2_N'(1);
                    if (state == STALE) begin
                        state     <= WAIT_FIRST;
                        bus.stale <= 1'b0;
                    end
                end
            end else if (state != STALE) begin
                if (tmo == TMO_LAST) begin
                    // Drop the partial window so stale samples never reach MPPT.
                    state          <= STALE;
                    bus.stale      <= 1'b1;
                    bus.data_ready <= 1'b0;
                    acc_v          <= '0;
                    acc_i          <= '0;
                    acc_c          <= '0;
                    cnt            <= '0;
                end else begin
                    tmo <= tmo + TW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_adc_frame_averager.sv
// Randomized and directed bench for adc_frame_averager against a cycle-level behavioural model.
module tb_adc_frame_averager;
    localparam int LOG2_N  = 2;
    localparam int TIMEOUT = 100;
    localparam int N       = 1 << LOG2_N;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adc_frame_averager_if bus();

    adc_frame_averager #(.LOG2_N(LOG2_N), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_seen_pulse = 0;

    // Reference model state: window sums, published values, flags.
    int m_sum_v, m_sum_i, m_sum_c, m_cnt, m_since;
    int m_av, m_ai, m_ac, m_p, m_err;
    bit m_pulse, m_ready, m_stale, m_prev_fv;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    function automatic void model_reset();
        m_sum_v = 0; m_sum_i = 0; m_sum_c = 0; m_cnt = 0; m_since = 0;
        m_av = 0; m_ai = 0; m_ac = 0; m_p = 0; m_err = 0;
        m_pulse = 0; m_ready = 0; m_stale = 0; m_prev_fv = 0;
    endfunction

    function automatic void clear_window();
        m_sum_v = 0; m_sum_i = 0; m_sum_c = 0; m_cnt = 0;
    endfunction

    function automatic void model_step(input bit fv, input logic [23:0] d);
        bit rising = fv && !m_prev_fv;
        bit acc    = rising && d != 24'h000000 && d != 24'hFFFFFF;
        m_prev_fv = fv;
        m_pulse   = 0;
        if (rising && !acc && m_err < 255) m_err++;
        if (acc) begin
            m_since = 0;
            m_stale = 0;
            m_sum_v += int'(d[23:16]);
            m_sum_i += int'(d[15:8]);
            m_sum_c += int'(d[7:0]);
            m_cnt++;
            if (m_cnt == N) begin
                m_av = m_sum_v / N;
                m_ai = m_sum_i / N;
                m_ac = m_sum_c / N;
                m_p  = m_av * m_ai;
                m_pulse = 1;
                m_ready = 1;
                clear_window();
            end
        end else begin
            m_since++;
            if (!m_stale && m_since >= TIMEOUT) begin
                m_stale = 1;
                m_ready = 0;
                clear_window();
            end
        end
    endfunction

    task automatic check_outputs();
        if (bus.avg_valid === 1'b1) n_seen_pulse++;
        chk("avg_valid",   bus.avg_valid,   m_pulse);
        chk("stale",       bus.stale,       m_stale);
        chk("data_ready",  bus.data_ready,  m_ready);
        chk("err_count",   bus.err_count,   m_err);
        chk("avg_v_panel", bus.avg_v_panel, m_av);
        chk("avg_i_panel", bus.avg_i_panel, m_ai);
        chk("avg_v_cap",   bus.avg_v_cap,   m_ac);
        chk("p_panel",     bus.p_panel,     m_p);
    endtask

    task automatic cycle(input bit fv, input logic [23:0] d);
        bus.frame_valid = fv;
        bus.frame_data  = d;
        @(negedge clk);
        model_step(fv, d);
        check_outputs();
    endtask

    task automatic send(input logic [23:0] d, input int hold);
        repeat (hold) cycle(1'b1, d);
        cycle(1'b0, d);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 24'h0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_v"},     bus.avg_v_panel, 0);
        chk({tag, "_i"},     bus.avg_i_panel, 0);
        chk({tag, "_c"},     bus.avg_v_cap,   0);
        chk({tag, "_p"},     bus.p_panel,     0);
        chk({tag, "_vld"},   bus.avg_valid,   0);
        chk({tag, "_ready"}, bus.data_ready,  0);
        chk({tag, "_stale"}, bus.stale,       0);
        chk({tag, "_err"},   bus.err_count,   0);
    endtask

    initial begin
        int pulses0;
        logic [23:0] d;
        bus.frame_valid = 1'b0;
        bus.frame_data  = 24'h0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_all_zero("rst");
        rst_n = 1'b1;

        // 1: idle after reset
        pulses0 = n_seen_pulse;
        idle(50);
        chk_all_zero("t1");
        chk("t1_pulses", n_seen_pulse - pulses0, 0);

        // 2: basic window
        pulses0 = n_seen_pulse;
        send({8'd10, 8'd4, 8'd100}, 1);
        send({8'd20, 8'd4, 8'd101}, 1);
        send({8'd30, 8'd4, 8'd102}, 1);
        send({8'd40, 8'd4, 8'd103}, 1);
        chk("t2_v", bus.avg_v_panel, 25);
        chk("t2_i", bus.avg_i_panel, 4);
        chk("t2_c", bus.avg_v_cap, 101);
        chk("t2_p", bus.p_panel, 100);
        chk("t2_ready", bus.data_ready, 1);
        chk("t2_pulses", n_seen_pulse - pulses0, 1);

        // 3: held level counts once
        pulses0 = n_seen_pulse;
        send(24'h0A0A0A, 10);
        repeat (3) send(24'h0A0A0A, 1);
        chk("t3_v", bus.avg_v_panel, 8'h0A);
        chk("t3_i", bus.avg_i_panel, 8'h0A);
        chk("t3_c", bus.avg_v_cap, 8'h0A);
        chk("t3_p", bus.p_panel, 100);
        chk("t3_pulses", n_seen_pulse - pulses0, 1);

        // 4: rejected idle-line frames
        pulses0 = n_seen_pulse;
        send(24'h102030, 1);
        send(24'h000000, 1);
        send(24'h203040, 1);
        send(24'hFFFFFF, 1);
        send(24'h304050, 1);
        chk("t4_early_pulses", n_seen_pulse - pulses0, 0);
        send(24'h405060, 1);
        chk("t4_err", bus.err_count, 2);
        chk("t4_v", bus.avg_v_panel, 40);
        chk("t4_i", bus.avg_i_panel, 56);
        chk("t4_c", bus.avg_v_cap, 72);
        chk("t4_p", bus.p_panel, 2240);
        chk("t4_pulses", n_seen_pulse - pulses0, 1);

        // 5: stale link and recovery
        send(24'h646464, 1);
        send(24'h646464, 1);
        idle(100);
        chk("t5_stale", bus.stale, 1);
        chk("t5_ready", bus.data_ready, 0);
        chk("t5_hold_v", bus.avg_v_panel, 40);
        chk("t5_hold_p", bus.p_panel, 2240);
        send(24'h080808, 1);
        chk("t5_stale_clr", bus.stale, 0);
        repeat (3) send(24'h080808, 1);
        chk("t5_v", bus.avg_v_panel, 8);
        chk("t5_i", bus.avg_i_panel, 8);
        chk("t5_c", bus.avg_v_cap, 8);
        chk("t5_p", bus.p_panel, 64);
        chk("t5_ready2", bus.data_ready, 1);

        // 6: error saturation, then async reset mid-window
        for (int k = 0; k < 300; k++) send((k % 2 == 0) ? 24'h000000 : 24'hFFFFFF, 1);
        chk("t6_err_sat", bus.err_count, 255);
        send(24'h112233, 1);
        send(24'h445566, 1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("t6_async");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        pulses0 = n_seen_pulse;
        repeat (3) send(24'h202020, 1);
        chk("t6_no_early", n_seen_pulse - pulses0, 0);
        send(24'h202020, 1);
        chk("t6_pulse", n_seen_pulse - pulses0, 1);
        chk("t6_v", bus.avg_v_panel, 8'h20);

        // Randomized traffic against the model
        for (int k = 0; k < 200; k++) begin
            int r;
            d = 24'($urandom);
            r = int'($urandom_range(0, 9));
            if (r == 0) d = 24'h000000;
            if (r == 1) d = 24'hFFFFFF;
            send(d, int'($urandom_range(1, 3)));
            idle(int'($urandom_range(0, 3)));
            if ($urandom_range(0, 29) == 0) idle(int'($urandom_range(95, 110)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/adc_frame_averager.md
Name: adc_frame_averager

Overview:
Sits between the 24-bit SMPS-side SPI slave and the MPPT/FSM logic. It takes each completed measurement frame {V_panel, I_panel, V_cap} and rejects frames with idle-line patterns. It block-averages accepted frames over 2^LOG2_N samples and publishes registered averages plus panel power. It also flags a stale link when frames stop arriving, so MPPT decisions never use stale measurements.

Parameters:
LOG2_N, 3, log2 of averaging window; legal range 1..6.
TIMEOUT, 50000000, clk cycles without an accepted frame before stale asserts (1 s at 50 MHz).

Ports:
clk  input  1  system clock (50 MHz).
rst_n  input  1  asynchronous active-low reset.
frame_data  input  24  frame from SPI slave: [23:16] V_panel, [15:8] I_panel, [7:0] V_cap.
frame_valid  input  1  SPI slave "sent" level, synchronous to clk; a new frame is indicated by its rising edge.
avg_v_panel  output  8  averaged panel voltage code.
avg_i_panel  output  8  averaged panel current code.
avg_v_cap  output  8  averaged capacitor voltage code.
p_panel  output  16  avg_v_panel * avg_i_panel, unsigned.
avg_valid  output  1  one-cycle pulse when the averages update.
data_ready  output  1  high once a window has been published; low while stale.
stale  output  1  no accepted frame for TIMEOUT cycles.
err_count  output  8  saturating count of rejected frames.

Behaviour:
- Reset (rst_n low, async): all outputs 0; accumulators, sample counter, timeout counter and edge-detect register cleared; state WAIT_FIRST.
- Edge detect: fv_q registers frame_valid. Event = frame_valid & ~fv_q. frame_data is sampled in the event cycle. A level held high counts once.
- Rejection: an event with frame_data == 24'h000000 or 24'hFFFFFF is rejected.
  - err_count increments and saturates at 255.
  - The sample is not accumulated and the timeout counter is not restarted.
- Accept: an event that is not rejected.
  - Adds each byte to its own accumulator. Accumulator width is 8+LOG2_N, unsigned, so it cannot overflow.
  - Increments the sample counter and clears the timeout counter.
- States:
  - WAIT_FIRST: after reset; accumulating; data_ready=0. The first complete window goes to RUN.
  - RUN: normal accumulation; data_ready=1.
  - STALE: entered from WAIT_FIRST or RUN when the timeout counter reaches TIMEOUT-1.
    - stale=1 and data_ready=0. Partial-window accumulators and the sample counter are cleared.
    - The average outputs hold their last values.
    - The first accepted frame clears stale in the next cycle, counts as sample 1 of a new window, and moves to WAIT_FIRST.
- Publish: on the accept that makes the count 2^LOG2_N, the following clock edge does all of the following:
  - Loads avg_* = (accumulator + sample) >> LOG2_N, truncating.
  - Loads p_panel from the new averages, computed combinationally from the sums, not the old registers.
  - Pulses avg_valid high for exactly one cycle and sets data_ready.
  - Zeros the accumulators and the sample counter.
- Latency: avg_valid is high in the cycle immediately after the event cycle of the last sample.
- Back-to-back: an event in the publish cycle counts as sample 1 of the next window. No frame is lost.
- Timeout counter: saturates at TIMEOUT-1 while stale; counts only in WAIT_FIRST and RUN.
- Simultaneous timeout expiry and accept in the same cycle: the accept wins. The counter clears and no stale is raised.
- Reset mid-window discards the partial window and returns all outputs to 0.

Test Plan:
Use LOG2_N=2 and TIMEOUT=100 for the bench.
1. Reset release, no frames for 50 cycles -> all outputs 0, avg_valid never pulses, stale=0.
2. Four frames V=10,20,30,40; I=4; Vcap=100,101,102,103 -> one cycle after the 4th edge: avg_v_panel=25, avg_i_panel=4, avg_v_cap=101 (406>>2, truncated), p_panel=100, avg_valid pulse of width 1, data_ready=1.
3. frame_valid held high for 10 cycles with data 0x0A0A0A, then three single-edge frames of 0x0A0A0A -> exactly 4 samples counted; averages all 0x0A; one avg_valid pulse.
4. Good, 0x000000, good, 0xFFFFFF, good, good -> err_count=2; publish only after the 4th good frame; averages exclude the rejected frames.
5. Two good frames then 100 idle cycles -> stale=1, data_ready=0, averages hold. Four new frames of V=I=Vcap=8 -> stale clears the cycle after the first frame; publish gives 8/8/8, p_panel=64 (old partial window discarded).
6. 300 rejected frames -> err_count=255 (saturated). Assert rst_n low mid-window after 2 good frames -> all outputs 0 asynchronously; after release a full window is required before avg_valid.
